// File: rtl/pipe_ctrl_hazard.sv
// Control unit for the 5-stage MIPS pipeline: ID-stage decode, load-use stall,
// branch/jump redirect, and the control bundle carried through EX, MEM and WB.
module pipe_ctrl_hazard #(
  parameter int ALU_W  = 4,
  parameter int REG_AW = 5,
  parameter bit EN_JAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              br_taken,
  output logic              stall,
  output logic              flush_if,
  output logic              jump,
  output logic              jump_reg,
  output logic [ALU_W-1:0]  ex_alu,
  output logic [1:0]        ex_src_a,
  output logic [1:0]        ex_src_b,
  output logic              ex_ext,
  output logic [1:0]        ex_branch,
  output logic              ex_illegal,
  output logic              ex_regwr,
  output logic              ex_mem2reg,
  output logic              ex_memwr,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_regwr,
  output logic              mem_mem2reg,
  output logic              mem_memwr,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_regwr,
  output logic              wb_mem2reg,
  output logic [REG_AW-1:0] wb_wreg
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(6);
  localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(7);
  localparam logic [ALU_W-1:0] ALU_SLTU = ALU_W'(8);
  localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(9);
  localparam logic [ALU_W-1:0] ALU_NOR  = ALU_W'(10);

  localparam logic [1:0] SRC_A_IMM16 = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT = 2'b10;
  localparam logic [1:0] SRC_A_LINK  = 2'b11;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_ZERO  = 2'b10;

  typedef struct packed {
    logic [ALU_W-1:0]  alu;
    logic [1:0]        src_a;
    logic [1:0]        src_b;
    logic              ext;
    logic [1:0]        branch;
    logic              illegal;
    logic              regwr;
    logic              mem2reg;
    logic              memwr;
    logic [REG_AW-1:0] wreg;
  } ctrl_t;

  ctrl_t             w_dec;
  ctrl_t             w_id_ex_next;
  ctrl_t             r_ex;
  logic              w_reads_rs;
  logic              w_reads_rt;
  logic              w_dec_jump;
  logic              w_dec_jr;
  logic              w_legal;
  logic              w_hazard;
  logic              w_br_flush;
  logic              r_mem_regwr;
  logic              r_mem_mem2reg;
  logic              r_mem_memwr;
  logic [REG_AW-1:0] r_mem_wreg;
  logic              r_wb_regwr;
  logic              r_wb_mem2reg;
  logic [REG_AW-1:0] r_wb_wreg;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_dec      = '0;
    w_reads_rs = 1'b0;
    w_reads_rt = 1'b0;
    w_dec_jump = 1'b0;
    w_dec_jr   = 1'b0;
    w_legal    = 1'b1;
    case (op)
      OP_RTYPE: begin
        w_dec.regwr = 1'b1;
        w_dec.wreg  = rd;
        w_reads_rs  = 1'b1;
        w_reads_rt  = 1'b1;
        case (funct)
          F_SLL: begin w_dec.alu = ALU_SLL; w_dec.src_a = SRC_A_SHAMT; w_reads_rs = 1'b0; end
          F_SRL: begin w_dec.alu = ALU_SRL; w_dec.src_a = SRC_A_SHAMT; w_reads_rs = 1'b0; end
          F_SRA: begin w_dec.alu = ALU_SRA; w_dec.src_a = SRC_A_SHAMT; w_reads_rs = 1'b0; end
          F_JR: begin
            w_dec.regwr = 1'b0;
            w_dec_jr    = 1'b1;
            w_legal     = EN_JAL;
          end
          F_ADD, F_ADDU: w_dec.alu = ALU_ADD;
          F_SUB, F_SUBU: w_dec.alu = ALU_SUB;
          F_AND:         w_dec.alu = ALU_AND;
          F_OR:          w_dec.alu = ALU_OR;
          F_XOR:         w_dec.alu = ALU_XOR;
          F_NOR:         w_dec.alu = ALU_NOR;
          F_SLT:         w_dec.alu = ALU_SLT;
          F_SLTU:        w_dec.alu = ALU_SLTU;
          default:       w_legal   = 1'b0;
        endcase
      end
      OP_J: w_dec_jump = 1'b1;
      OP_JAL: begin
        w_dec.regwr = 1'b1;
        w_dec.src_a = SRC_A_LINK;
        w_dec.src_b = SRC_B_ZERO;
        w_dec.wreg  = REG_AW'(31);
        w_dec_jump  = 1'b1;
        w_legal     = EN_JAL;
      end
      OP_BEQ, OP_BNE: begin
        w_dec.alu    = ALU_SUB;
        w_dec.ext    = 1'b1;
        w_dec.branch = (op == OP_BEQ) ? 2'b01 : 2'b10;
        w_reads_rs   = 1'b1;
        w_reads_rt   = 1'b1;
      end
      OP_LW, OP_SW: begin
        w_dec.alu     = ALU_ADD;
        w_dec.src_b   = SRC_B_IMM;
        w_dec.ext     = 1'b1;
        w_dec.regwr   = (op == OP_LW);
        w_dec.mem2reg = (op == OP_LW);
        w_dec.memwr   = (op == OP_SW);
        w_dec.wreg    = (op == OP_LW) ? rt : '0;
        w_reads_rs    = 1'b1;
        w_reads_rt    = (op == OP_SW);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_dec.src_b = SRC_B_IMM;
        w_dec.regwr = 1'b1;
        w_dec.wreg  = rt;
        w_reads_rs  = 1'b1;
        case (op)
          OP_ADDI:  begin w_dec.alu = ALU_ADD; w_dec.ext = 1'b1; end
          OP_ADDIU: w_dec.alu = ALU_ADD;
          OP_SLTI:  begin w_dec.alu = ALU_SLT; w_dec.ext = 1'b1; end
          OP_SLTIU: w_dec.alu = ALU_SLTU;
          OP_ANDI:  w_dec.alu = ALU_AND;
          OP_ORI:   w_dec.alu = ALU_OR;
          OP_XORI:  w_dec.alu = ALU_XOR;
          default: begin
            w_dec.alu   = ALU_SLL;
            w_dec.src_a = SRC_A_IMM16;
            w_reads_rs  = 1'b0;
          end
        endcase
      end
      default: w_legal = 1'b0;
    endcase

    // Empty slots and undecodable words both leave ID as a bubble; only the
    // latter raises the illegal flag downstream.
    if (!id_valid || !w_legal) begin
      w_dec         = '0;
      w_dec.illegal = id_valid & ~w_legal;
      w_reads_rs    = 1'b0;
      w_reads_rt    = 1'b0;
      w_dec_jump    = 1'b0;
      w_dec_jr      = 1'b0;
    end
  end

  assign w_br_flush = br_taken & (r_ex.branch != 2'b00);
  assign w_hazard   = id_valid & r_ex.mem2reg & r_ex.regwr & (r_ex.wreg != '0) &
                      ((w_reads_rs & (r_ex.wreg == rs)) | (w_reads_rt & (r_ex.wreg == rt)));

  assign stall    = w_hazard & ~w_br_flush;
  assign jump     = w_dec_jump & ~w_hazard & ~w_br_flush;
  assign jump_reg = w_dec_jr & ~w_hazard & ~w_br_flush;
  assign flush_if = w_br_flush | jump | jump_reg;

  assign w_id_ex_next = (w_hazard | w_br_flush) ? ctrl_t'('0) : w_dec;

  // NOTE: pipeline registers use non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex          <= '0;
      r_mem_regwr   <= 1'b0;
      r_mem_mem2reg <= 1'b0;
      r_mem_memwr   <= 1'b0;
      r_mem_wreg    <= '0;
      r_wb_regwr    <= 1'b0;
      r_wb_mem2reg  <= 1'b0;
      r_wb_wreg     <= '0;
    end else begin
      r_ex          <= w_id_ex_next;
      r_mem_regwr   <= r_ex.regwr;
      r_mem_mem2reg <= r_ex.mem2reg;
      r_mem_memwr   <= r_ex.memwr;
      r_mem_wreg    <= r_ex.wreg;
      r_wb_regwr    <= r_mem_regwr;
      r_wb_mem2reg  <= r_mem_mem2reg;
      r_wb_wreg     <= r_mem_wreg;
    end
  end

  assign ex_alu      = r_ex.alu;
  assign ex_src_a    = r_ex.src_a;
  assign ex_src_b    = r_ex.src_b;
  assign ex_ext      = r_ex.ext;
  assign ex_branch   = r_ex.branch;
  assign ex_illegal  = r_ex.illegal;
  assign ex_regwr    = r_ex.regwr;
  assign ex_mem2reg  = r_ex.mem2reg;
  assign ex_memwr    = r_ex.memwr;
  assign ex_wreg     = r_ex.wreg;
  assign mem_regwr   = r_mem_regwr;
  assign mem_mem2reg = r_mem_mem2reg;
  assign mem_memwr   = r_mem_memwr;
  assign mem_wreg    = r_mem_wreg;
  assign wb_regwr    = r_wb_regwr;
  assign wb_mem2reg  = r_wb_mem2reg;
  assign wb_wreg     = r_wb_wreg;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard: directed scenarios plus a randomized run checked
// against an instruction-level reference model of the control pipeline.
module tb_pipe_ctrl_hazard;

  localparam logic [5:0] OP_R = 6'd0,  OP_J = 6'd2,  OP_JAL = 6'd3, OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5, OP_SLTIU = 6'd11, OP_LUI = 6'd15;
  localparam logic [5:0] OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [5:0] F_SRA = 6'd3, F_JR = 6'd8, F_ADD = 6'd32, F_NOR = 6'd39;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       br_taken;

  logic       stall, flush_if, jump, jump_reg;
  logic [3:0] ex_alu;
  logic [1:0] ex_src_a, ex_src_b, ex_branch;
  logic       ex_ext, ex_illegal, ex_regwr, ex_mem2reg, ex_memwr;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic       mem_regwr, mem_mem2reg, mem_memwr, wb_regwr, wb_mem2reg;

  logic       nj_stall, nj_flush_if, nj_jump, nj_jump_reg;
  logic [3:0] nj_ex_alu;
  logic [1:0] nj_ex_src_a, nj_ex_src_b, nj_ex_branch;
  logic       nj_ex_ext, nj_ex_illegal, nj_ex_regwr, nj_ex_mem2reg, nj_ex_memwr;
  logic [4:0] nj_ex_wreg, nj_mem_wreg, nj_wb_wreg;
  logic       nj_mem_regwr, nj_mem_mem2reg, nj_mem_memwr, nj_wb_regwr, nj_wb_mem2reg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_hazard #(.ALU_W(4), .REG_AW(5), .EN_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .br_taken(br_taken),
    .stall(stall), .flush_if(flush_if), .jump(jump), .jump_reg(jump_reg),
    .ex_alu(ex_alu), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_ext(ex_ext),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .ex_regwr(ex_regwr),
    .ex_mem2reg(ex_mem2reg), .ex_memwr(ex_memwr), .ex_wreg(ex_wreg),
    .mem_regwr(mem_regwr), .mem_mem2reg(mem_mem2reg), .mem_memwr(mem_memwr),
    .mem_wreg(mem_wreg), .wb_regwr(wb_regwr), .wb_mem2reg(wb_mem2reg), .wb_wreg(wb_wreg)
  );

  pipe_ctrl_hazard #(.ALU_W(4), .REG_AW(5), .EN_JAL(1'b0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .br_taken(br_taken),
    .stall(nj_stall), .flush_if(nj_flush_if), .jump(nj_jump), .jump_reg(nj_jump_reg),
    .ex_alu(nj_ex_alu), .ex_src_a(nj_ex_src_a), .ex_src_b(nj_ex_src_b), .ex_ext(nj_ex_ext),
    .ex_branch(nj_ex_branch), .ex_illegal(nj_ex_illegal), .ex_regwr(nj_ex_regwr),
    .ex_mem2reg(nj_ex_mem2reg), .ex_memwr(nj_ex_memwr), .ex_wreg(nj_ex_wreg),
    .mem_regwr(nj_mem_regwr), .mem_mem2reg(nj_mem_mem2reg), .mem_memwr(nj_mem_memwr),
    .mem_wreg(nj_mem_wreg), .wb_regwr(nj_wb_regwr), .wb_mem2reg(nj_wb_mem2reg),
    .wb_wreg(nj_wb_wreg)
  );

  // ---------------- reference model ----------------
  typedef enum int {
    I_BUB, I_ILL, I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR, I_SLT,
    I_SLTU, I_SLL, I_SRL, I_SRA, I_JR, I_J, I_JAL, I_BEQ, I_BNE, I_ADDI, I_ADDIU,
    I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_SW
  } mn_t;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] sa, sb;
    logic       ext;
    logic [1:0] br;
    logic       ill, rw, m2r, mw;
    logic [4:0] wr;
    logic       wr_chk, dp_chk;
  } exp_t;

  function automatic mn_t classify(logic v, logic [5:0] o, logic [5:0] f);
    mn_t m;
    m = I_ILL;
    if (!v) m = I_BUB;
    else case (o)
      6'd0: case (f)
        6'd0: m = I_SLL;   6'd2: m = I_SRL;   6'd3: m = I_SRA;   6'd8: m = I_JR;
        6'd32: m = I_ADD;  6'd33: m = I_ADDU; 6'd34: m = I_SUB;  6'd35: m = I_SUBU;
        6'd36: m = I_AND;  6'd37: m = I_OR;   6'd38: m = I_XOR;  6'd39: m = I_NOR;
        6'd42: m = I_SLT;  6'd43: m = I_SLTU;
        default: m = I_ILL;
      endcase
      6'd2: m = I_J;      6'd3: m = I_JAL;    6'd4: m = I_BEQ;   6'd5: m = I_BNE;
      6'd8: m = I_ADDI;   6'd9: m = I_ADDIU;  6'd10: m = I_SLTI; 6'd11: m = I_SLTIU;
      6'd12: m = I_ANDI;  6'd13: m = I_ORI;   6'd14: m = I_XORI; 6'd15: m = I_LUI;
      6'd35: m = I_LW;    6'd43: m = I_SW;
      default: m = I_ILL;
    endcase
    return m;
  endfunction

  function automatic exp_t bubble();
    exp_t b;
    b = '0;
    b.wr_chk = 1'b1;
    b.dp_chk = 1'b1;
    return b;
  endfunction

  function automatic exp_t ref_decode(mn_t m, logic [4:0] rt_i, logic [4:0] rd_i,
                                      output logic rrs, output logic rrt,
                                      output logic jmp, output logic jr);
    exp_t e;
    logic r_alu, i_alu;
    e = bubble();
    case (m)
      I_SUB, I_SUBU, I_BEQ, I_BNE: e.alu = 4'd1;
      I_SLL, I_LUI:                e.alu = 4'd2;
      I_SRL:                       e.alu = 4'd3;
      I_SLT, I_SLTI:               e.alu = 4'd4;
      I_AND, I_ANDI:               e.alu = 4'd5;
      I_OR, I_ORI:                 e.alu = 4'd6;
      I_XOR, I_XORI:               e.alu = 4'd7;
      I_SLTU, I_SLTIU:             e.alu = 4'd8;
      I_SRA:                       e.alu = 4'd9;
      I_NOR:                       e.alu = 4'd10;
      default:                     e.alu = 4'd0;
    endcase
    r_alu = m inside {I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR,
                      I_SLT, I_SLTU, I_SLL, I_SRL, I_SRA};
    i_alu = m inside {I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW};
    if (m inside {I_SLL, I_SRL, I_SRA}) e.sa = 2'b10;
    if (m == I_LUI) e.sa = 2'b01;
    if (m == I_JAL) begin e.sa = 2'b11; e.sb = 2'b10; end
    if (i_alu || m == I_SW) e.sb = 2'b01;
    e.ext    = m inside {I_ADDI, I_SLTI, I_LW, I_SW, I_BEQ, I_BNE};
    e.br     = (m == I_BEQ) ? 2'b01 : (m == I_BNE) ? 2'b10 : 2'b00;
    e.ill    = (m == I_ILL);
    e.rw     = r_alu || i_alu || m == I_JAL;
    e.m2r    = (m == I_LW);
    e.mw     = (m == I_SW);
    e.wr     = r_alu ? rd_i : i_alu ? rt_i : (m == I_JAL) ? 5'd31 : 5'd0;
    e.wr_chk = e.rw || m inside {I_BUB, I_ILL};
    e.dp_chk = !(m inside {I_J, I_JR});
    rrs = !(m inside {I_BUB, I_ILL, I_J, I_JAL, I_LUI, I_SLL, I_SRL, I_SRA});
    rrt = r_alu && !(m inside {I_SLL, I_SRL, I_SRA}) || m inside {I_SLL, I_SRL, I_SRA, I_JR, I_SW, I_BEQ, I_BNE};
    jmp = m inside {I_J, I_JAL};
    jr  = (m == I_JR);
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [5:0] op_pool [18] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8,
                               6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
  logic [5:0] fn_pool [15] = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36,
                               6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd1};

  task automatic set_id(input logic v, input logic [5:0] o, input logic [5:0] f,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    id_valid = v; op = o; funct = f; rs = a; rt = b; rd = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    br_taken = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pick_random_id();
    id_valid = ($urandom_range(0, 9) != 0);
    op       = ($urandom_range(0, 15) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 17)];
    funct    = ($urandom_range(0, 15) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 14)];
    rs       = 5'($urandom_range(0, 3));
    rt       = 5'($urandom_range(0, 3));
    rd       = 5'($urandom_range(0, 3));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    br_taken = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ex_regwr, ex_illegal, ex_wreg, wb_regwr, wb_wreg} !== 13'd0) begin
      n_fail++; $display("FAIL reset_initial got=%b exp=0", {ex_regwr, ex_illegal, ex_wreg, wb_regwr, wb_wreg});
    end
    rst_n = 1'b1;
    set_id(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd3);
    repeat (3) tick();
    n_checks++;
    if ({ex_regwr, mem_regwr, wb_regwr, wb_wreg} !== {3'b111, 5'd3}) begin
      n_fail++; $display("FAIL reset_prefill got=%b exp=%b", {ex_regwr, mem_regwr, wb_regwr, wb_wreg}, {3'b111, 5'd3});
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ex_alu, ex_src_a, ex_src_b, ex_ext, ex_branch, ex_illegal, ex_regwr, ex_mem2reg,
         ex_memwr, ex_wreg, mem_regwr, mem_mem2reg, mem_memwr, mem_wreg, wb_regwr,
         wb_mem2reg, wb_wreg} !== 35'd0) begin
      n_fail++; $display("FAIL reset_midcycle ex_wreg=%0d mem_wreg=%0d wb_wreg=%0d exp all 0", ex_wreg, mem_wreg, wb_wreg);
    end
    #1 rst_n = 1'b1;
    set_id(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    n_checks++;
    if ({ex_regwr, ex_wreg, ex_alu} !== {1'b1, 5'd3, 4'd0}) begin
      n_fail++; $display("FAIL reset_add_ex got=%b exp=%b", {ex_regwr, ex_wreg, ex_alu}, {1'b1, 5'd3, 4'd0});
    end
    set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    n_checks++;
    if ({wb_regwr, wb_wreg} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL reset_add_wb got=%b exp=%b", {wb_regwr, wb_wreg}, {1'b1, 5'd3});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b1, OP_R, F_ADD, 5'd5, 5'd6, 5'd7);
    #1;
    n_checks++;
    if ({stall, flush_if} !== 2'b10) begin
      n_fail++; $display("FAIL lu_stall got=%b exp=10", {stall, flush_if});
    end
    tick();
    n_checks++;
    if ({ex_regwr, ex_mem2reg, ex_memwr, stall} !== 4'b0000) begin
      n_fail++; $display("FAIL lu_bubble_one_cycle got=%b exp=0000", {ex_regwr, ex_mem2reg, ex_memwr, stall});
    end
    tick();
    n_checks++;
    if ({ex_regwr, ex_alu, ex_wreg} !== {1'b1, 4'd0, 5'd7}) begin
      n_fail++; $display("FAIL lu_add_ex got=%b exp=%b", {ex_regwr, ex_alu, ex_wreg}, {1'b1, 4'd0, 5'd7});
    end
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd6, 5'd0);
    tick();
    set_id(1'b1, OP_R, F_ADD, 5'd1, 5'd6, 5'd7);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_rt_stall got=%b exp=1", stall);
    end
    tick();
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OP_R, F_ADD, 5'd0, 5'd0, 5'd7);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_r0_nostall got=%b exp=0", stall);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    set_id(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OP_J, 6'd0, 5'd0, 5'd0, 5'd0);
    br_taken = 1'b1;
    #1;
    n_checks++;
    if ({ex_branch, flush_if, jump, jump_reg, stall} !== 6'b01_1000) begin
      n_fail++; $display("FAIL br_flush got=%b exp=011000", {ex_branch, flush_if, jump, jump_reg, stall});
    end
    tick();
    n_checks++;
    if ({ex_regwr, ex_branch, ex_illegal} !== 4'b0000) begin
      n_fail++; $display("FAIL br_bubble got=%b exp=0000", {ex_regwr, ex_branch, ex_illegal});
    end
    set_id(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd3);
    #1;
    n_checks++;
    if (flush_if !== 1'b0) begin
      n_fail++; $display("FAIL br_nobranch_noflush got=%b exp=0", flush_if);
    end
    tick();
    br_taken = 1'b0;
    n_checks++;
    if ({ex_regwr, ex_wreg} !== {1'b1, 5'd3}) begin
      n_fail++; $display("FAIL br_add_passes got=%b exp=%b", {ex_regwr, ex_wreg}, {1'b1, 5'd3});
    end
  endtask

  task automatic test_jal();
    do_reset();
    set_id(1'b1, OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0);
    #1;
    n_checks++;
    if ({jump, flush_if, nj_jump, nj_flush_if} !== 4'b1100) begin
      n_fail++; $display("FAIL jal_redirect got=%b exp=1100", {jump, flush_if, nj_jump, nj_flush_if});
    end
    tick();
    n_checks++;
    if ({ex_wreg, ex_src_a, ex_src_b, ex_regwr, ex_alu} !== {5'd31, 2'b11, 2'b10, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL jal_ex got=%b exp=%b", {ex_wreg, ex_src_a, ex_src_b, ex_regwr, ex_alu},
                         {5'd31, 2'b11, 2'b10, 1'b1, 4'd0});
    end
    n_checks++;
    if ({nj_ex_illegal, nj_ex_regwr, nj_ex_mem2reg, nj_ex_memwr, nj_ex_wreg} !== {4'b1000, 5'd0}) begin
      n_fail++; $display("FAIL jal_disabled got=%b exp=100000000", {nj_ex_illegal, nj_ex_regwr, nj_ex_mem2reg, nj_ex_memwr, nj_ex_wreg});
    end
    set_id(1'b1, OP_R, F_JR, 5'd4, 5'd0, 5'd0);
    #1;
    n_checks++;
    if ({jump_reg, jump, flush_if, nj_jump_reg} !== 4'b1010) begin
      n_fail++; $display("FAIL jr_redirect got=%b exp=1010", {jump_reg, jump, flush_if, nj_jump_reg});
    end
    tick();
    n_checks++;
    if ({ex_regwr, ex_illegal, nj_ex_illegal} !== 3'b001) begin
      n_fail++; $display("FAIL jr_ex got=%b exp=001", {ex_regwr, ex_illegal, nj_ex_illegal});
    end
  endtask

  task automatic test_alu_ops();
    do_reset();
    set_id(1'b1, OP_R, F_SRA, 5'd1, 5'd2, 5'd3);
    tick();
    n_checks++;
    if ({ex_alu, ex_src_a} !== {4'd9, 2'b10}) begin
      n_fail++; $display("FAIL sra got=%b exp=%b", {ex_alu, ex_src_a}, {4'd9, 2'b10});
    end
    set_id(1'b1, OP_R, F_NOR, 5'd1, 5'd2, 5'd3);
    tick();
    n_checks++;
    if ({ex_alu, ex_src_a} !== {4'd10, 2'b00}) begin
      n_fail++; $display("FAIL nor got=%b exp=%b", {ex_alu, ex_src_a}, {4'd10, 2'b00});
    end
    set_id(1'b1, 6'b111111, 6'd0, 5'd1, 5'd2, 5'd3);
    #1;
    n_checks++;
    if ({jump, jump_reg, flush_if} !== 3'b000) begin
      n_fail++; $display("FAIL illegal_noredirect got=%b exp=000", {jump, jump_reg, flush_if});
    end
    tick();
    n_checks++;
    if ({ex_illegal, ex_regwr, ex_mem2reg, ex_memwr, ex_branch} !== 6'b100000) begin
      n_fail++; $display("FAIL illegal_ex got=%b exp=100000", {ex_illegal, ex_regwr, ex_mem2reg, ex_memwr, ex_branch});
    end
    set_id(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    n_checks++;
    if ({ex_illegal, ex_regwr} !== 2'b01) begin
      n_fail++; $display("FAIL illegal_clear got=%b exp=01", {ex_illegal, ex_regwr});
    end
  endtask

  task automatic test_imm();
    do_reset();
    set_id(1'b1, OP_SLTIU, 6'd0, 5'd1, 5'd2, 5'd0);
    #1;
    n_checks++;
    if (jump !== 1'b0) begin
      n_fail++; $display("FAIL sltiu_jump got=%b exp=0", jump);
    end
    tick();
    n_checks++;
    if ({ex_alu, ex_ext, ex_branch, ex_src_b, ex_wreg} !== {4'd8, 1'b0, 2'b00, 2'b01, 5'd2}) begin
      n_fail++; $display("FAIL sltiu_ex got=%b exp=%b", {ex_alu, ex_ext, ex_branch, ex_src_b, ex_wreg},
                         {4'd8, 1'b0, 2'b00, 2'b01, 5'd2});
    end
    set_id(1'b1, OP_LW, 6'd0, 5'd1, 5'd9, 5'd0);
    tick();
    set_id(1'b1, OP_LUI, 6'd0, 5'd9, 5'd10, 5'd0);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL lui_nostall got=%b exp=0", stall);
    end
    tick();
    n_checks++;
    if ({ex_src_a, ex_alu, ex_regwr, ex_wreg} !== {2'b01, 4'd2, 1'b1, 5'd10}) begin
      n_fail++; $display("FAIL lui_ex got=%b exp=%b", {ex_src_a, ex_alu, ex_regwr, ex_wreg}, {2'b01, 4'd2, 1'b1, 5'd10});
    end
  endtask

  task automatic test_random();
    exp_t e_ex, e_mem, e_wb, d;
    mn_t  m;
    logic rrs, rrt, jmp, jr, hz, bf, e_stall, e_jump, e_jr, e_flush, hold;
    do_reset();
    e_ex = bubble(); e_mem = bubble(); e_wb = bubble();
    hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) pick_random_id();
      br_taken = ($urandom_range(0, 3) == 0);
      #1;
      m  = classify(id_valid, op, funct);
      d  = ref_decode(m, rt, rd, rrs, rrt, jmp, jr);
      hz = id_valid && e_ex.m2r && e_ex.rw && (e_ex.wr != 5'd0) &&
           ((rrs && e_ex.wr == rs) || (rrt && e_ex.wr == rt));
      bf = br_taken && (e_ex.br != 2'b00);
      e_stall = hz && !bf;
      e_jump  = jmp && !hz && !bf;
      e_jr    = jr && !hz && !bf;
      e_flush = bf || e_jump || e_jr;
      n_checks++;
      if ({stall, flush_if, jump, jump_reg} !== {e_stall, e_flush, e_jump, e_jr}) begin
        n_fail++; $display("FAIL rand_id cyc=%0d op=%0d fn=%0d got=%b exp=%b", cyc, op, funct,
                           {stall, flush_if, jump, jump_reg}, {e_stall, e_flush, e_jump, e_jr});
      end
      tick();
      e_wb  = e_mem;
      e_mem = e_ex;
      e_ex  = (hz || bf) ? bubble() : d;
      hold  = e_stall;
      n_checks++;
      if ({ex_branch, ex_illegal, ex_regwr, ex_mem2reg, ex_memwr} !== {e_ex.br, e_ex.ill, e_ex.rw, e_ex.m2r, e_ex.mw}) begin
        n_fail++; $display("FAIL rand_ex_ctrl cyc=%0d got=%b exp=%b", cyc,
                           {ex_branch, ex_illegal, ex_regwr, ex_mem2reg, ex_memwr}, {e_ex.br, e_ex.ill, e_ex.rw, e_ex.m2r, e_ex.mw});
      end
      if (e_ex.dp_chk) begin
        n_checks++;
        if ({ex_alu, ex_src_a, ex_src_b, ex_ext} !== {e_ex.alu, e_ex.sa, e_ex.sb, e_ex.ext}) begin
          n_fail++; $display("FAIL rand_ex_dp cyc=%0d got=%b exp=%b", cyc,
                             {ex_alu, ex_src_a, ex_src_b, ex_ext}, {e_ex.alu, e_ex.sa, e_ex.sb, e_ex.ext});
        end
      end
      if (e_ex.wr_chk) begin
        n_checks++;
        if (ex_wreg !== e_ex.wr) begin
          n_fail++; $display("FAIL rand_ex_wreg cyc=%0d got=%0d exp=%0d", cyc, ex_wreg, e_ex.wr);
        end
      end
      n_checks++;
      if ({mem_regwr, mem_mem2reg, mem_memwr, wb_regwr, wb_mem2reg} !== {e_mem.rw, e_mem.m2r, e_mem.mw, e_wb.rw, e_wb.m2r}) begin
        n_fail++; $display("FAIL rand_mem_wb_ctrl cyc=%0d got=%b exp=%b", cyc,
                           {mem_regwr, mem_mem2reg, mem_memwr, wb_regwr, wb_mem2reg}, {e_mem.rw, e_mem.m2r, e_mem.mw, e_wb.rw, e_wb.m2r});
      end
      if (e_mem.wr_chk) begin
        n_checks++;
        if (mem_wreg !== e_mem.wr) begin
          n_fail++; $display("FAIL rand_mem_wreg cyc=%0d got=%0d exp=%0d", cyc, mem_wreg, e_mem.wr);
        end
      end
      if (e_wb.wr_chk) begin
        n_checks++;
        if (wb_wreg !== e_wb.wr) begin
          n_fail++; $display("FAIL rand_wb_wreg cyc=%0d got=%0d exp=%0d", cyc, wb_wreg, e_wb.wr);
        end
      end
    end
    br_taken = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_flush();
    test_jal();
    test_alu_ops();
    test_imm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
